// File: rtl/fp_single_pkg.sv
// Shared single-precision field layout, flag indices and pipeline occupancy encoding
// for the registered floating-point subtract wrapper.
package fp_single_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int MANT_HI  = 22;
  localparam int MANT_LO  = 0;

  localparam logic [7:0]  EXP_MAX   = 8'hFF;
  localparam logic [31:0] NAN_CANON = 32'h7FC00000;

  localparam int FLAG_INVALID  = 3;
  localparam int FLAG_OVERFLOW = 2;
  localparam int FLAG_ZERO     = 1;
  localparam int FLAG_SPECIAL  = 0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_t;

  // Denormals become a zero of the same sign when flushing is enabled.
  function automatic logic [31:0] ftz_flush(input logic [31:0] x, input logic ftz);
    if (ftz && (x[EXP_HI:EXP_LO] == 8'h00)) return {x[SIGN_BIT], 31'h0};
    return x;
  endfunction

endpackage

// File: rtl/fp_classify_single.sv
// Combinational zero / infinity / NaN classification of one single-precision operand.
module fp_classify_single
  import fp_single_pkg::*;
#(
  parameter int FTZ = 1
) (
  input  logic [31:0] x,
  output logic        zero,
  output logic        inf,
  output logic        nan
);

  logic [7:0] exp_f;
  logic       mant_nz;

  assign exp_f   = x[EXP_HI:EXP_LO];
  assign mant_nz = |x[MANT_HI:MANT_LO];

  assign zero = (exp_f == 8'h00) && ((FTZ != 0) || !mant_nz);
  assign inf  = (exp_f == EXP_MAX) && !mant_nz;
  assign nan  = (exp_f == EXP_MAX) && mant_nz;

endmodule

// File: rtl/fp_sub_pipe_single.sv
// Two-stage valid/ready wrapper around an external combinational single-precision
// subtractor: S1 registers operands for the core, S2 registers result and flags.
module fp_sub_pipe_single
  import fp_single_pkg::*;
#(
  parameter int          FTZ     = 1,
  parameter logic [31:0] NAN_VAL = NAN_CANON
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  input  logic [31:0] core_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  occ_state_t  state_reg, state_next;
  logic        s1_valid_reg;
  logic [31:0] core_a_reg, core_b_reg;
  logic        out_valid_reg;
  logic [31:0] result_reg;
  logic [3:0]  flags_reg;

  logic        accept, drain, s2_load;
  logic [31:0] res_next;
  logic [3:0]  flags_next;
  logic        inv_next, ovf_next, special_next;

  logic [31:0] opnd [2];
  logic [1:0]  is_zero, is_inf, is_nan;
  logic        sign_a, sign_b;

  assign opnd[0] = core_a_reg;
  assign opnd[1] = core_b_reg;
  assign sign_a  = core_a_reg[SIGN_BIT];
  assign sign_b  = core_b_reg[SIGN_BIT];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cls
      fp_classify_single #(.FTZ(FTZ)) u_cls (
        .x    (opnd[gi]),
        .zero (is_zero[gi]),
        .inf  (is_inf[gi]),
        .nan  (is_nan[gi])
      );
    end
  endgenerate

  // Only a full pipe with a stalled consumer blocks input, so in_ready never
  // looks at in_valid.
  assign in_ready = (state_reg != OCC_TWO) || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_reg && out_ready;
  assign s2_load  = !out_valid_reg || out_ready;

  always_comb begin
    res_next     = core_out;
    inv_next     = 1'b0;
    ovf_next     = 1'b0;
    special_next = 1'b1;
    if (|is_nan) begin
      res_next = NAN_VAL;
      inv_next = 1'b1;
    end else if (is_inf[0] && is_inf[1] && (sign_a == sign_b)) begin
      res_next = NAN_VAL;
      inv_next = 1'b1;
    end else if (is_inf[0]) begin
      res_next = core_a_reg;
    end else if (is_inf[1]) begin
      res_next = {~sign_b, core_b_reg[EXP_HI:MANT_LO]};
    end else if (core_a_reg == core_b_reg) begin
      res_next = 32'h0;
    end else if (is_zero[1]) begin
      // Also covers both operands zero, since a==b was already excluded.
      res_next = core_a_reg;
    end else if (is_zero[0]) begin
      res_next = {~sign_b, core_b_reg[EXP_HI:MANT_LO]};
    end else begin
      special_next = 1'b0;
      if (core_out[EXP_HI:EXP_LO] == EXP_MAX) begin
        ovf_next = 1'b1;
        res_next = {core_out[SIGN_BIT], EXP_MAX, 23'h0};
      end
    end
    flags_next                = 4'b0000;
    flags_next[FLAG_INVALID]  = inv_next;
    flags_next[FLAG_OVERFLOW] = ovf_next;
    flags_next[FLAG_ZERO]     = (res_next[EXP_HI:MANT_LO] == 31'h0);
    flags_next[FLAG_SPECIAL]  = special_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      core_a_reg    <= 32'h0;
      core_b_reg    <= 32'h0;
      out_valid_reg <= 1'b0;
      result_reg    <= 32'h0;
      flags_reg     <= 4'b0000;
    end else begin
      if (accept) begin
        s1_valid_reg <= 1'b1;
        core_a_reg   <= ftz_flush(a, FTZ != 0);
        core_b_reg   <= ftz_flush(b, FTZ != 0);
      end else if (s2_load) begin
        s1_valid_reg <= 1'b0;
      end
      if (s2_load) begin
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          result_reg <= res_next;
          flags_reg  <= flags_next;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= OCC_EMPTY;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      OCC_EMPTY: if (accept) state_next = OCC_ONE;
      OCC_ONE: begin
        if (accept && !drain)      state_next = OCC_TWO;
        else if (drain && !accept) state_next = OCC_EMPTY;
      end
      OCC_TWO:   if (drain && !accept) state_next = OCC_ONE;
      default:   state_next = OCC_EMPTY;
    endcase
  end

  assign core_a    = core_a_reg;
  assign core_b    = core_b_reg;
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign flags     = flags_reg;

endmodule

// File: doc/fp_sub_pipe_single.md
FP_SUB_PIPE_SINGLE -- requirements
Module: fp_sub_pipe_single

Interface
REQ-001 Parameter FTZ, default 1: flush denormal operands to signed zero before use.
REQ-002 Parameter NAN_VAL, default 32'h7FC00000: canonical quiet NaN returned on invalid operations.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand pair a, b presented.
REQ-006 in_ready  output  1  stage accepts the operand pair this cycle.
REQ-007 a  input  32  IEEE-754 single-precision minuend.
REQ-008 b  input  32  IEEE-754 single-precision subtrahend.
REQ-009 core_a, core_b  output  32 each  registered operands driven to the combinational subtractor sub_fp_single.
REQ-010 core_out  input  32  sub_fp_single result for core_a - core_b.
REQ-011 out_valid  output  1  result and flags valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 result  output  32  a - b, single precision.
REQ-014 flags  output  4  {invalid, overflow, zero, special}; special = result produced by the bypass path, not the core.

Function
REQ-015 Two-stage pipeline: S1 holds the classified operands; S2 holds the registered result and flags; latency in_valid&&in_ready to out_valid is exactly 2 cycles with no stall.
REQ-016 Transfer occurs only on valid&&ready; a held beat's payload stays stable until accepted.
REQ-017 S2 loads when S2 is empty or out_ready=1; S1 advances into S2 only when S2 loads.
REQ-018 in_ready = !s1_valid || (S2 loads this cycle); it depends on no combinational path from in_valid.
REQ-019 Full throughput: with out_ready held 1, one pair is accepted every cycle.
REQ-020 Occupancy FSM EMPTY / ONE / TWO, tracking valid beats in S1+S2; EMPTY->ONE on accept, ONE->TWO on accept without drain, TWO->ONE on drain without accept, ONE->EMPTY on drain without accept; simultaneous accept and drain leaves the state unchanged.
REQ-021 S1 classification per operand: zero (exp=0 with FTZ=1, or exp=0 and mant=0), inf (exp=FF, mant=0), NaN (exp=FF, mant!=0).
REQ-022 Bypass priority, highest first: any NaN -> NAN_VAL, invalid=1; inf-inf with equal signs -> NAN_VAL, invalid=1; a inf -> a; b inf -> b with sign inverted; a==b bitwise -> 32'h00000000; b zero -> a; a zero -> b with sign inverted; both zero -> +0.
REQ-023 When no bypass applies, result = core_out as sampled while the beat sits in S1, special=0.
REQ-024 overflow=1 when a non-bypass result has exp=FF; that result is then forced to signed infinity (mantissa 0).
REQ-025 zero=1 whenever result[30:0]=0, regardless of path.
REQ-026 core_a and core_b hold their last values while S1 is empty or stalled; they are not cleared.

Reset
REQ-027 On rst_n=0: s1_valid=0, out_valid=0, FSM=EMPTY, result=0, flags=0, core_a=core_b=0; in_ready reads 1 one cycle after release.
REQ-028 Reset asserted mid-operation discards all in-flight beats; no result of a pre-reset beat appears after release.

Structure
REQ-029 Shared package fp_single_pkg holds the field positions (sign 31, exp 30:23, mant 22:0), EXP_MAX=8'hFF, the canonical NaN, the flag bit indices and the occupancy state encoding.
REQ-030 One sub-module, fp_classify_single (combinational; outputs zero/inf/nan per operand), instantiated twice; sub_fp_single is instantiated by the integrating level, not inside this block.

Verification
REQ-031 a=40400000 (3.0), b=3F800000 (1.0), out_ready=1 -> result 40000000 (2.0), flags 0000, 2 cycles after accept.
REQ-032 a=7F800000, b=7F800000 -> result 7FC00000, flags 1001; a=3F800000, b=FF800000 -> result 7F800000, flags 0001.
REQ-033 a=b=41200000 -> result 00000000, flags 0011; a=00000001 (denormal), b=3F800000, FTZ=1 -> result BF800000, flags 0001.
REQ-034 Stream 8 pairs with out_ready toggling 1,0,0,1,... -> all 8 results in order, none dropped or duplicated, in_ready=0 exactly when FSM=TWO and out_ready=0.
REQ-035 Core model returning exp=FF for a non-bypass pair -> result 7F800000 or FF800000 per sign, flags 0100.
REQ-036 Assert rst_n=0 with FSM=TWO -> out_valid=0 asynchronously, no stale result after release, next pair returns correctly in 2 cycles.
